// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles and flags a stuck input.
// Optional `PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-cycle persistence filter after the synchronizer.
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_RISE | no reference rise yet (after reset or timeout)
// HIGH      | counting period and high time since the last rise
// LOW       | counting period only; high time frozen until next rise
module pwm_capture #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             s1_q, s2_q, s3_q;
    logic             lvl;
    logic             rise, fall, timeout;

    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Level follows s2 only after s2 has disagreed for 3 consecutive cycles.
    logic       filt_q;
    logic [1:0] filt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= 2'd0;
        end else if (s2_q != filt_q) begin
            if (filt_cnt_q == 2'd2) begin
                filt_q     <= s2_q;
                filt_cnt_q <= 2'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 2'd1;
            end
        end else begin
            filt_cnt_q <= 2'd0;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= lvl;
        end
    end

    assign rise = lvl & ~s3_q;
    assign fall = ~lvl & s3_q;
    // Once flagged, the saturated counter must not re-sample the level: flags hold until a rise.
    assign timeout = (period_cnt_q == TIMEOUT_VAL) && !rise && !(stuck_high_q || stuck_low_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_RISE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (timeout) begin
                    state_d = WAIT_RISE;
                end else if (fall) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (timeout) begin
                    state_d = WAIT_RISE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase
    end

    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        if (timeout) begin
            stuck_high_d = lvl;
            stuck_low_d  = ~lvl;
            period_d     = '0;
            high_time_d  = '0;
        end else begin
            case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        period_cnt_d = ONE;
                        high_cnt_d   = ONE;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                    end else if (period_cnt_q != TIMEOUT_VAL) begin
                        period_cnt_d = period_cnt_q + ONE;
                    end
                end
                HIGH: begin
                    period_cnt_d = period_cnt_q + ONE;
                    if (!fall) begin
                        high_cnt_d = high_cnt_q + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d     = period_cnt_q;
                        high_time_d  = high_cnt_q;
                        meas_valid_d = 1'b1;
                        period_cnt_d = ONE;
                        high_cnt_d   = ONE;
                    end else begin
                        period_cnt_d = period_cnt_q + ONE;
                    end
                end
                default: begin
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected measurements are queued by the stimulus and
// checked by an independent monitor on every meas_valid strobe.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic        stuck_high;
    logic        stuck_low;

    int checks = 0;
    int errors = 0;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [15:0] p;
        logic [15:0] h;
    } exp_t;

    exp_t exp_q[$];

    pwm_capture #(.CNT_W(16), .TIMEOUT_CYCLES(4095)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] p, input logic [15:0] h);
        exp_t e;
        e.p = p;
        e.h = h;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_period(input int h, input int l);
        pwm_in = 1'b1;
        wait_cyc(h);
        pwm_in = 1'b0;
        wait_cyc(l);
    endtask

    task automatic glitch_period();
        pwm_in = 1'b1;
        wait_cyc(64);
        pwm_in = 1'b0;
        wait_cyc(100);
        pwm_in = 1'b1;
        wait_cyc(1);
        pwm_in = 1'b0;
        wait_cyc(91);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_period"}, 32'(period), 0);
        chk({name, "_high_time"}, 32'(high_time), 0);
        chk({name, "_meas_valid"}, 32'(meas_valid), 0);
        chk({name, "_stuck_high"}, 32'(stuck_high), 0);
        chk({name, "_stuck_low"}, 32'(stuck_low), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (meas_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: period=%0d high_time=%0d, no strobe expected (t=%0t)",
                             period, high_time, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_period", 32'(period), 32'(e.p));
                    chk("strobe_high_time", 32'(high_time), 32'(e.h));
                end
            end
        end
    end

    initial begin : stimulus
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        wait_cyc(3);
        check_idle("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        // duty 64 / 256: first strobe only at the second rise
        run_period(64, 192);
        push(256, 64);
        run_period(64, 192);
        push(256, 64);
        run_period(64, 192);
        push(256, 64);
        run_period(64, 192);

        // duty step 64 -> 200
        push(256, 64);
        run_period(200, 56);
        push(256, 200);
        run_period(200, 56);
        push(256, 200);
        run_period(64, 192);

        // 1-cycle high glitch inside the low phase
        push(256, 64);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        push(164, 64);
`endif
        glitch_period();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        push(256, 64);
`else
        push(92, 1);
`endif
        run_period(64, 192);

        // input stuck high after a valid measurement
        push(256, 64);
        pwm_in = 1'b1;
        wait_cyc(4095 + LAT);
        chk("stuck_high_early", 32'(stuck_high), 0);
        wait_cyc(1);
        chk("stuck_high_set", 32'(stuck_high), 1);
        chk("stuck_high_low_flag", 32'(stuck_low), 0);
        chk("stuck_high_period", 32'(period), 0);
        chk("stuck_high_high_time", 32'(high_time), 0);

        // duty 0 after reset
        rst_n = 1'b0;
        wait_cyc(2);
        check_idle("reset2");
        pwm_in = 1'b0;
        rst_n  = 1'b1;
        wait_cyc(4095);
        chk("stuck_low_early", 32'(stuck_low), 0);
        wait_cyc(1);
        chk("stuck_low_set", 32'(stuck_low), 1);
        chk("stuck_low_high_flag", 32'(stuck_high), 0);
        chk("stuck_low_period", 32'(period), 0);
        chk("stuck_low_high_time", 32'(high_time), 0);
        run_period(64, 192);
        chk("stuck_low_cleared", 32'(stuck_low), 0);

        // reset pulse asserted mid-HIGH at duty 128
        push(256, 64);
        run_period(128, 128);
        push(256, 128);
        pwm_in = 1'b1;
        wait_cyc(64);
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_high");
        wait_cyc(64);
        pwm_in = 1'b0;
        wait_cyc(30);
        rst_n = 1'b1;
        wait_cyc(98);
        run_period(128, 128);
        push(256, 128);
        run_period(128, 128);
        push(256, 128);
        run_period(128, 128);
        push(256, 128);
        pwm_in = 1'b1;
        wait_cyc(20);
        pwm_in = 1'b0;
        wait_cyc(10);

        chk("outstanding_expected", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: the period and the high time in `clk` cycles, with a one-cycle strobe after each complete period. It is the receive-side counterpart to the LED/PWM generator on the 12 MHz CMOD A7 top level. It sits on a `pio` input, either looped back from the generator's `pio1` output or driven by an external source. Results feed status logic or LED indicators.

## Interface
Parameters:
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `TIMEOUT_CYCLES`, 4095: cycles without a rising edge before the input is declared stuck. Must be ≤ 2^CNT_W − 1.

Ports:
- `clk`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  reset; one clock, asynchronous active-low reset.
- `pwm_in`  in  1  PWM input, asynchronous to `clk`.
- `period`  out  CNT_W  last measured rising-to-rising interval in cycles.
- `high_time`  out  CNT_W  last measured high interval in cycles.
- `meas_valid`  out  1  one-cycle strobe when `period`/`high_time` update.
- `stuck_high`  out  1  timeout expired with input high; level.
- `stuck_low`  out  1  timeout expired with input low; level.

## Operation
- **Input conditioning:** 2-flop synchronizer gives `s2`, and `s3` is its delayed copy. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- **State machine:** three states: `WAIT_RISE`, `HIGH`, `LOW`. Reset state is `WAIT_RISE`.
- **`WAIT_RISE`:** `period_cnt` increments, saturating at `TIMEOUT_CYCLES`. On `rise`: `period_cnt<=1`, `high_cnt<=1`, go to `HIGH`, and clear both stuck flags. No strobe, because there is no prior rise to measure from.
- **`HIGH`:** `period_cnt++` and `high_cnt++` each cycle. On `fall`: go to `LOW`, and `high_cnt` is frozen at its current value.
- **`LOW`:** `period_cnt++` each cycle. On `rise`:
  - `period<=period_cnt` and `high_time<=high_cnt`.
  - `meas_valid<=1` for one cycle.
  - `period_cnt<=1`, `high_cnt<=1`, go to `HIGH`.
- **Resulting values:** a rise at cycle 0, fall at cycle F and next rise at cycle P yield `period=P` and `high_time=F`.
- **Timeout:** in any state, when `period_cnt == TIMEOUT_CYCLES` and no `rise` occurs that cycle:
  - `stuck_high<=s2` and `stuck_low<=~s2`.
  - `period<=0` and `high_time<=0`.
  - go to `WAIT_RISE`; no strobe.
  - The flags hold until the next `rise`.
- **Counter width:** counters never wrap. Timeout fires before saturation.
- **Simultaneous events:**
  - `rise` and timeout in the same cycle: `rise` wins (measurement taken, no stuck flag).
  - `rise` and `fall` cannot coincide.
- **Reset mid-operation:** asserting `rst_n` low immediately clears every register, returns to `WAIT_RISE` and discards any partial measurement.

## Timing
- All outputs reset to 0.
- Edge latency: `pwm_in` first sampled high at edge n → `rise` is active in the cycle after edge n+1 → registered `meas_valid`/`period` visible after edge n+2.
- The same delay applies to both edges, so the measured `period` and `high_time` are exact for inputs synchronous to `clk`. Asynchronous inputs carry ±1 cycle jitter.
- `meas_valid` is high for exactly one cycle per period.
- `period`/`high_time` are stable between strobes.
- The minimum measurable phase is 1 cycle high or 1 cycle low; e.g. duty 255/256 is reported as `high_time=255`, `period=256`.
- Stuck flags assert at the edge where the timeout condition is registered.

## Configuration
- **`PWM_CAPTURE_GLITCH_FILTER_EN` defined:**
  - A filter is inserted after `s2`. The filtered level changes only after `s2` has held the new value for 3 consecutive cycles.
  - Edge detection and the stuck-flag sampling use the filtered level.
  - High or low pulses shorter than 3 cycles are ignored.
  - Edge latency grows by 3 cycles on both edges, so measurements are unchanged.
  - Filter reset value is 0.
- **Undefined:** no filter; `s2` is used directly and every pulse ≥1 cycle is measured.

## Test plan
- Drive a reset, then a 256-cycle PWM with duty 64, synchronous to `clk`. Expect `meas_valid` to first strobe at the second rise, with `period=256`, `high_time=64`, then one strobe every 256 cycles with the same values.
- Step the duty 64→200 mid-stream. Expect the first strobe after the change to report `high_time=200`, `period=256`, with no spurious strobe.
- Hold `pwm_in=0` (duty 0) after reset. Expect `stuck_low=1` after 4095 cycles (plus latency), `stuck_high=0`, outputs 0 and no strobes. A later rise clears the flag.
- Hold `pwm_in=1` after one valid measurement. Expect `stuck_high=1`, and `period`/`high_time` forced to 0 at timeout.
- Pulse `rst_n` low mid-HIGH phase at duty 128. Expect all outputs to be 0 immediately. The first strobe comes only at the second rise after reset, with `period=256`, `high_time=128`.
- Inject a 1-cycle high glitch inside the low phase at duty 64. With `PWM_CAPTURE_GLITCH_FILTER_EN`: expect no extra strobe and values unchanged. Without it: expect an extra strobe with a short `period` and `high_time=1`.
